// File: rtl/acl_spi_reader_if.sv
// Bus between the ADXL362 reader and its surroundings: the SPI pins plus the
// packed sample output with its strobes.
interface acl_spi_reader_if;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [14:0] acl_data;
    logic        data_valid;
    logic        cfg_done;

    modport master (
        input  miso,
        output sclk, mosi, cs_n, acl_data, data_valid, cfg_done
    );

    modport slave (
        output miso,
        input  sclk, mosi, cs_n, acl_data, data_valid, cfg_done
    );
endinterface

// File: rtl/acl_spi_reader.sv
// ADXL362 SPI master: puts the sensor in measurement mode once after reset,
// then periodically burst-reads X/Y/Z and publishes their top 5 bits.
module acl_spi_reader #(
    parameter int CLK_DIV        = 50,
    parameter int STARTUP_CYCLES = 1_000_000,
    parameter int SAMPLE_PERIOD  = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    acl_spi_reader_if.master  bus
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int STU_W = $clog2(STARTUP_CYCLES + 1);
    localparam int SMP_W = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [STU_W-1:0] STU_LAST = STU_W'(STARTUP_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_PERIOD - 1);

    // Frames are left-aligned in a 40-bit shifter; unused tail bits stay zero.
    localparam logic [39:0] CFG_FRAME  = {24'h0A2D02, 16'h0000};
    localparam logic [39:0] READ_FRAME = {16'h0B08, 24'h000000};

    localparam logic [2:0] STARTUP = 3'd0;
    localparam logic [2:0] CFG     = 3'd1;
    localparam logic [2:0] GAP     = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] READ    = 3'd4;
    localparam logic [2:0] LATCH   = 3'd5;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       half_cnt;
    logic [STU_W-1:0] startup_cnt;
    logic [SMP_W-1:0] sample_cnt;
    logic [39:0]      tx;
    logic [14:0]      cap;
    logic             sclk_q;
    logic             cs_n_q;
    logic [14:0]      acl_q;
    logic             dv_q;
    logic             cfg_q;

    logic       tick;
    logic       sample_due;
    logic       start_cfg;
    logic       start_read;
    logic [6:0] half_last;
    logic [5:0] bit_idx;
    logic       keep_bit;

    assign tick       = (div_cnt == DIV_LAST);
    assign sample_due = (sample_cnt == SMP_LAST);
    assign start_cfg  = (state == STARTUP) && (startup_cnt == STU_LAST);
    assign start_read = sample_due && ((state == WAIT) || ((state == GAP) && tick));
    assign half_last  = (state == READ) ? 7'd80 : 7'd48;

    // Only bits [7:3] of each data byte are kept, so the capture register
    // holds exactly the packed sample once the frame completes.
    assign bit_idx  = half_cnt[6:1];
    assign keep_bit = (state == READ) && (bit_idx >= 6'd16) && (half_cnt[3:1] < 3'd5);

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STARTUP;
            div_cnt     <= '0;
            half_cnt    <= '0;
            startup_cnt <= '0;
            tx          <= '0;
            cap         <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            acl_q       <= '0;
            dv_q        <= 1'b0;
            cfg_q       <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state)
                STARTUP: startup_cnt <= startup_cnt + 1'b1;
                CFG, READ: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 7'd1;
                        if (half_cnt == half_last) begin
                            cs_n_q <= 1'b1;
                            state  <= (state == READ) ? LATCH : GAP;
                            if (state == CFG) cfg_q <= 1'b1;
                        end else if (!half_cnt[0]) begin
                            sclk_q <= 1'b1;
                            if (keep_bit) cap <= {cap[13:0], bus.miso};
                        end else begin
                            sclk_q <= 1'b0;
                            tx     <= {tx[38:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    acl_q   <= cap;
                    dv_q    <= 1'b1;
                    div_cnt <= div_cnt + 1'b1;
                    state   <= GAP;
                end
                GAP: begin
                    if (tick) state <= WAIT;
                    else      div_cnt <= div_cnt + 1'b1;
                end
                WAIT:    ;
                default: state <= STARTUP;
            endcase

            // Frame start overrides whatever the case above chose.
            if (start_cfg || start_read) begin
                state    <= start_read ? READ : CFG;
                tx       <= start_read ? READ_FRAME : CFG_FRAME;
                cs_n_q   <= 1'b0;
                sclk_q   <= 1'b0;
                div_cnt  <= '0;
                half_cnt <= '0;
            end
        end
    end

    // Free-running, saturating; restarts at every read so starts are periodic.
    always_ff @(posedge clk) begin
        if (rst)             sample_cnt <= '0;
        else if (start_read) sample_cnt <= '0;
        else if (!sample_due) sample_cnt <= sample_cnt + 1'b1;
    end

    assign bus.sclk       = sclk_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.mosi       = tx[39];
    assign bus.acl_data   = acl_q;
    assign bus.data_valid = dv_q;
    assign bus.cfg_done   = cfg_q;

endmodule

// File: tb/tb_acl_spi_reader.sv
// Directed bench for acl_spi_reader: an ADXL362 slave model feeds both a
// periodic-sampling instance and a back-to-back instance.
module tb_acl_spi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic sel   = 1'b0;

    acl_spi_reader_if bus_a();
    acl_spi_reader_if bus_b();

    acl_spi_reader #(.CLK_DIV(2), .STARTUP_CYCLES(10), .SAMPLE_PERIOD(300)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    acl_spi_reader #(.CLK_DIV(2), .STARTUP_CYCLES(10), .SAMPLE_PERIOD(50)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );

    logic        mon_cs, mon_sclk, mon_mosi, mon_dv, mon_cfg, mon_rst;
    logic [14:0] mon_acl;
    assign mon_cs   = sel ? bus_b.cs_n       : bus_a.cs_n;
    assign mon_sclk = sel ? bus_b.sclk       : bus_a.sclk;
    assign mon_mosi = sel ? bus_b.mosi       : bus_a.mosi;
    assign mon_dv   = sel ? bus_b.data_valid : bus_a.data_valid;
    assign mon_cfg  = sel ? bus_b.cfg_done   : bus_a.cfg_done;
    assign mon_acl  = sel ? bus_b.acl_data   : bus_a.acl_data;
    assign mon_rst  = sel ? rst_b            : rst_a;

    // Slave: presents resp MSB first, advancing after each observed sclk rise.
    logic [39:0] resp  = '0;
    logic [5:0]  rises = '0;
    logic        slave_miso;
    assign slave_miso = (!mon_cs && rises < 6'd40) ? resp[6'd39 - rises] : 1'b0;
    assign bus_a.miso = slave_miso;
    assign bus_b.miso = slave_miso;

    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_rst = 1'b1, p_dv = 1'b0;
    logic [14:0] p_acl = '0;
    logic [39:0] shift = '0, f_data = '0;
    int cyc = 0, low_len = 0, high_len = 0;
    int f_start = 0, f_high = 0, f_low = 0, f_bits = 0, frame_cnt = 0;
    int dv_cnt = 0, dv_multi = 0, mosi_viol = 0, acl_viol = 0;

    always @(posedge clk) begin
        p_cs   <= mon_cs;
        p_sclk <= mon_sclk;
        p_mosi <= mon_mosi;
        p_rst  <= mon_rst;
        p_dv   <= mon_dv;
        p_acl  <= mon_acl;
        cyc    <= cyc + 1;
        if (p_cs && !mon_cs) begin
            f_start <= cyc;
            f_high  <= high_len;
            low_len <= 1;
            rises   <= '0;
            shift   <= '0;
        end else if (!mon_cs) begin
            low_len <= low_len + 1;
        end
        if (!p_cs && mon_cs) begin
            f_low     <= low_len;
            f_bits    <= int'(rises);
            f_data    <= shift;
            frame_cnt <= frame_cnt + 1;
            rises     <= '0;
            high_len  <= 1;
        end else if (mon_cs) begin
            high_len <= high_len + 1;
        end
        if (!mon_cs && mon_sclk && !p_sclk) begin
            rises <= rises + 6'd1;
            shift <= {shift[38:0], mon_mosi};
        end
        if (mon_mosi != p_mosi && !(p_sclk && !mon_sclk) && !(p_cs && !mon_cs) && !p_rst)
            mosi_viol <= mosi_viol + 1;
        if (mon_dv) dv_cnt <= dv_cnt + 1;
        if (mon_dv && p_dv) dv_multi <= dv_multi + 1;
        if (mon_acl != p_acl && !mon_dv && !p_rst) acl_viol <= acl_viol + 1;
    end

    int checks = 0;
    int errors = 0;
    int prev_start = 0;

    task automatic wait_frame(input int tmo, output bit ok);
        int start_cnt;
        start_cnt = frame_cnt;
        ok = 1'b0;
        for (int i = 0; i < tmo; i++) begin
            @(negedge clk);
            if (frame_cnt != start_cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", bus_a.cs_n); end
        checks++; if (bus_a.sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", bus_a.sclk); end
        checks++; if (bus_a.mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus_a.mosi); end
        checks++; if (bus_a.acl_data !== 15'h0) begin errors++; $display("FAIL reset_acl: got %h expected 0000", bus_a.acl_data); end
        checks++; if (bus_a.data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", bus_a.data_valid); end
        checks++; if (bus_a.cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done: got %b expected 0", bus_a.cfg_done); end
    endtask

    task automatic test_startup_cfg(input string name);
        int n;
        bit ok;
        if (sel) rst_b = 1'b0;
        else     rst_a = 1'b0;
        n = 0;
        while (mon_cs === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL %s_startup_len: got %0d expected 10", name, n); end
        checks++; if (mon_cfg !== 1'b0) begin errors++; $display("FAIL %s_cfg_done_early: got %b expected 0", name, mon_cfg); end
        wait_frame(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_cfg_timeout: got none expected frame", name); end
        checks++; if (f_bits != 24) begin errors++; $display("FAIL %s_cfg_bits: got %0d expected 24", name, f_bits); end
        checks++; if (f_data[23:0] !== 24'h0A2D02) begin errors++; $display("FAIL %s_cfg_data: got %h expected 0a2d02", name, f_data[23:0]); end
        checks++; if (f_low != 98) begin errors++; $display("FAIL %s_cfg_cs_low: got %0d expected 98", name, f_low); end
        checks++; if (mon_cfg !== 1'b1) begin errors++; $display("FAIL %s_cfg_done: got %b expected 1", name, mon_cfg); end
    endtask

    task automatic test_read(input string name, input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] z, input logic [14:0] exp, input bit chk_space,
                             input int exp_space, input int min_high, input int max_high);
        bit ok;
        int dv0;
        resp = {16'h0000, x, y, z};
        dv0 = dv_cnt;
        wait_frame(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got none expected frame", name); end
        checks++; if (f_bits != 40) begin errors++; $display("FAIL %s_bits: got %0d expected 40", name, f_bits); end
        checks++; if (f_data[39:24] !== 16'h0B08) begin errors++; $display("FAIL %s_cmd: got %h expected 0b08", name, f_data[39:24]); end
        checks++; if (f_data[23:0] !== 24'h0) begin errors++; $display("FAIL %s_mosi_tail: got %h expected 000000", name, f_data[23:0]); end
        checks++; if (f_low != 162) begin errors++; $display("FAIL %s_cs_low: got %0d expected 162", name, f_low); end
        checks++;
        if (f_high < min_high || f_high > max_high) begin
            errors++; $display("FAIL %s_gap: got %0d expected %0d..%0d", name, f_high, min_high, max_high);
        end
        if (chk_space) begin
            checks++;
            if (f_start - prev_start != exp_space) begin
                errors++; $display("FAIL %s_spacing: got %0d expected %0d", name, f_start - prev_start, exp_space);
            end
        end
        prev_start = f_start;
        checks++; if (mon_dv !== 1'b1) begin errors++; $display("FAIL %s_dv_pulse: got %b expected 1", name, mon_dv); end
        checks++; if (mon_acl !== exp) begin errors++; $display("FAIL %s_acl: got %h expected %h", name, mon_acl, exp); end
        @(negedge clk);
        checks++; if (mon_dv !== 1'b0) begin errors++; $display("FAIL %s_dv_width: got %b expected 0", name, mon_dv); end
        checks++; if (mon_acl !== exp) begin errors++; $display("FAIL %s_acl_hold: got %h expected %h", name, mon_acl, exp); end
        checks++; if (dv_cnt != dv0 + 1) begin errors++; $display("FAIL %s_dv_count: got %0d expected %0d", name, dv_cnt - dv0, 1); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        resp = {16'h0000, 8'hAA, 8'h55, 8'hCC};
        n = 0;
        while (!(mon_cs === 1'b0 && rises == 6'd20) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 1000) begin errors++; $display("FAIL midrst_reach_bit20: got timeout expected bit 20"); end
        rst_a = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n: got %b expected 1", bus_a.cs_n); end
        checks++; if (bus_a.sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b expected 0", bus_a.sclk); end
        checks++; if (bus_a.acl_data !== 15'h0) begin errors++; $display("FAIL midrst_acl: got %h expected 0000", bus_a.acl_data); end
        checks++; if (bus_a.cfg_done !== 1'b0) begin errors++; $display("FAIL midrst_cfg_done: got %b expected 0", bus_a.cfg_done); end
        @(negedge clk);
        test_startup_cfg("restart");
    endtask

    task automatic test_back_to_back();
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        sel = 1'b1;
        repeat (2) @(negedge clk);
        test_startup_cfg("b2b");
        test_read("b2b_r1", 8'h7F, 8'h80, 8'h18, 15'h3E03, 1'b0, 0,   2, 2);
        test_read("b2b_r2", 8'hFF, 8'h08, 8'hF7, 15'h7C3E, 1'b1, 164, 2, 2);
        test_read("b2b_r3", 8'h00, 8'hFF, 8'h87, 15'h03F0, 1'b1, 164, 2, 2);
    endtask

    task automatic test_protocol();
        checks++; if (mosi_viol != 0) begin errors++; $display("FAIL mosi_timing: got %0d changes expected 0", mosi_viol); end
        checks++; if (dv_multi != 0) begin errors++; $display("FAIL dv_multi_cycle: got %0d expected 0", dv_multi); end
        checks++; if (acl_viol != 0) begin errors++; $display("FAIL acl_change_no_dv: got %0d expected 0", acl_viol); end
    endtask

    initial begin
        test_reset();
        test_startup_cfg("boot");
        test_read("read1", 8'h7F, 8'h80, 8'h18, 15'h3E03, 1'b0, 0,   2, 1000);
        test_read("read2", 8'hFF, 8'h08, 8'hF7, 15'h7C3E, 1'b1, 300, 2, 1000);
        test_reset_mid_read();
        test_back_to_back();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
